rect_fill: RTL and testbench

RECT_FILL -- requirements
Module: rect_fill

---
 rtl/vga_pkg.sv | 23 ++
 rtl/pix_addr_gen.sv | 13 +
 rtl/rect_fill.sv | 149 ++++++++++++++
 tb/tb_rect_fill.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA controller-side definitions: frame geometry, draw FSM encoding, palette.
package vga_pkg;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StDraw  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [2:0] PalBlack      = 3'd0;
  localparam logic [2:0] PalBlue       = 3'd1;
  localparam logic [2:0] PalRed        = 3'd2;
  localparam logic [2:0] PalMagenta    = 3'd3;
  localparam logic [2:0] PalGreen      = 3'd4;
  localparam logic [2:0] PalCyan       = 3'd5;
  localparam logic [2:0] PalYellow     = 3'd6;
  localparam logic [2:0] PalGreenWhite = 3'd7;

endpackage

// File: rtl/pix_addr_gen.sv
// Linear pixel address y*640+x built from shifts and adds.
module pix_addr_gen (
  input  logic [9:0]  x_i,
  input  logic [8:0]  y_i,
  output logic [18:0] addr_o
);

  // y*512 + y*128 + x
  always_comb begin
    addr_o = {1'b0, y_i, 9'b0} + {3'b0, y_i, 7'b0} + {9'b0, x_i};
  end

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: clips a command to the frame and streams its pixels in raster order.
module rect_fill
  import vga_pkg::*;
(
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [2:0]  cmd_color,
  input  logic        ready,
  output logic [18:0] Waddr,
  output logic [2:0]  Wdata,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d, w_q, w_d, cur_x_q, cur_x_d;
  logic [8:0]  y_q, y_d, h_q, h_d, cur_y_q, cur_y_d;
  logic [2:0]  color_q, color_d, wdata_q, wdata_d;
  logic [10:0] x_end_q, x_end_d, x_sum, x_end_c;
  logic [9:0]  y_end_q, y_end_d, y_sum, y_end_c;
  logic [18:0] waddr_q, waddr_d, gen_addr;
  logic        empty_rect, last_col, last_row, load_addr;

  // Address of the cursor position being loaded this cycle
  pix_addr_gen u_pix_addr_gen (
    .x_i    (cur_x_d),
    .y_i    (cur_y_d),
    .addr_o (gen_addr)
  );

  // Clip against the frame; sums are one bit wider so they cannot wrap
  always_comb begin
    x_sum      = {1'b0, x_q} + {1'b0, w_q};
    y_sum      = {1'b0, y_q} + {1'b0, h_q};
    x_end_c    = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
    y_end_c    = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
    empty_rect = ({1'b0, x_q} >= 11'(H_RES)) || ({1'b0, y_q} >= 10'(V_RES)) ||
                 (w_q == '0) || (h_q == '0);
    last_col   = (({1'b0, cur_x_q} + 11'd1) == x_end_q);
    last_row   = (({1'b0, cur_y_q} + 10'd1) == y_end_q);
  end

  // Next-state, command latch and cursor stepping
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    x_end_d   = x_end_q;
    y_end_d   = y_end_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    wdata_d   = wdata_q;
    load_addr = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = StSetup;
        end
      end
      StSetup: begin
        x_end_d = x_end_c;
        y_end_d = y_end_c;
        if (empty_rect) begin
          state_d = StDone;
        end else begin
          state_d   = StDraw;
          cur_x_d   = x_q;
          cur_y_d   = y_q;
          wdata_d   = color_q;
          load_addr = 1'b1;
        end
      end
      StDraw: begin
        // ready=0 holds everything; last pixel leaves Waddr on the final address
        if (ready) begin
          if (last_col && last_row) begin
            state_d = StDone;
          end else if (last_col) begin
            cur_x_d   = x_q;
            cur_y_d   = cur_y_q + 9'd1;
            load_addr = 1'b1;
          end else begin
            cur_x_d   = cur_x_q + 10'd1;
            load_addr = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output address register only moves when a new cursor position is loaded
  always_comb begin
    waddr_d = load_addr ? gen_addr : waddr_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign Waddr     = waddr_q;
  assign Wdata     = wdata_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill with an expected-address scoreboard.
module tb_rect_fill;

  logic        clk_100mhz = 1'b0;
  logic        rst, cmd_valid, cmd_ready, ready, busy, done;
  logic [9:0]  cmd_x, cmd_w;
  logic [8:0]  cmd_y, cmd_h;
  logic [2:0]  cmd_color, Wdata;
  logic [18:0] Waddr;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int last_addr = 0;
  int last_color = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  rect_fill dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_color  (cmd_color),
    .ready      (ready),
    .Waddr      (Waddr),
    .Wdata      (Wdata),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_waddr"}, 32'(Waddr), 0);
    check({tag, "_wdata"}, 32'(Wdata), 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after completion.
  // rmode: 0 = ready always high, 1 = ready toggles 1,0,1,0. rst_at: pixel index to reset on.
  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input int rmode, input int rst_at, input bit hold);
    int xe, ye, n, cyc;
    bit r;
    check("accept_ready", 32'(cmd_ready), 1);
    cmd_x = 10'(x);
    cmd_y = 9'(y);
    cmd_w = 10'(w);
    cmd_h = 9'(h);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    exp_q.delete();
    xe = (x + w > 640) ? 640 : x + w;
    ye = (y + h > 480) ? 480 : y + h;
    if (x < 640 && y < 480 && w > 0 && h > 0)
      for (int yy = y; yy < ye; yy++)
        for (int xx = x; xx < xe; xx++) exp_q.push_back(yy * 640 + xx);
    @(negedge clk_100mhz);
    if (!hold) cmd_valid = 1'b0;
    check("setup_busy", 32'(busy), 1);
    check("setup_cmd_ready", 32'(cmd_ready), 0);
    check("setup_done", 32'(done), 0);
    @(negedge clk_100mhz);
    n = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      check("draw_addr", 32'(Waddr), exp_q[0]);
      check("draw_data", 32'(Wdata), c);
      check("draw_cmd_ready", 32'(cmd_ready), 0);
      check("draw_done", 32'(done), 0);
      r = (rmode == 0) ? 1'b1 : (cyc % 2 == 0);
      ready = r;
      if (r && rst_at == n) begin
        rst = 1'b1;
        @(negedge clk_100mhz);
        rst = 1'b0;
        cmd_valid = 1'b0;
        check_reset_state("midrst");
        exp_q.delete();
        last_addr = 0;
        last_color = 0;
        ready = 1'b1;
        return;
      end
      if (r) begin
        last_addr = exp_q.pop_front();
        last_color = c;
        n++;
      end
      cyc++;
      @(negedge clk_100mhz);
    end
    check("draw_timeout", 32'(exp_q.size()), 0);
    ready = 1'b1;
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 1);
    check("done_cmd_ready", 32'(cmd_ready), 0);
    check("done_waddr_hold", 32'(Waddr), last_addr);
    check("done_wdata_hold", 32'(Wdata), last_color);
    @(negedge clk_100mhz);
    check("idle_done_low", 32'(done), 0);
    check("idle_busy_low", 32'(busy), 0);
    check("idle_cmd_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b1;  // reset must win over a pending command
    ready = 1'b1;
    cmd_x = '0;
    cmd_y = '0;
    cmd_w = 10'd4;
    cmd_h = 9'd4;
    cmd_color = 3'd5;
    repeat (3) @(negedge clk_100mhz);
    check_reset_state("reset");
    rst = 1'b0;
    cmd_valid = 1'b0;

    run_cmd(10, 20, 3, 2, 3, 0, -1, 1'b0);   // basic 3x2, ready tied high
    run_cmd(10, 20, 3, 2, 3, 1, -1, 1'b0);   // same with ready toggling
    run_cmd(638, 478, 5, 5, 6, 0, -1, 1'b0); // clipped at bottom-right corner
    run_cmd(100, 100, 0, 4, 2, 0, -1, 1'b0); // zero width
    run_cmd(700, 10, 4, 4, 1, 0, -1, 1'b0);  // x off-screen
    run_cmd(0, 0, 10, 10, 5, 0, 3, 1'b0);    // reset at 4th pixel
    run_cmd(1, 2, 2, 2, 7, 1, -1, 1'b0);     // accepted right after reset
    run_cmd(5, 1, 2, 2, 7, 0, -1, 1'b1);     // cmd_valid held through busy
    run_cmd(0, 479, 3, 1, 4, 1, -1, 1'b0);   // back-to-back second command

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
